// File: rtl/soc_mem_arbiter.sv
// Shares one memory port between the CV32E instruction and data requesters.
// Address phase is arbitrated; responses return in order through a source-ID FIFO.
module soc_mem_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int DATA_PRIO       = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instr_addr_i,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_spurious_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);
  localparam logic SRC_INSTR = 1'b0;
  localparam logic SRC_DATA  = 1'b1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                     state_reg, state_next;
  logic                       locked_src_reg, locked_src_next;
  logic                       rr_last_reg;
  logic [MAX_OUTSTANDING-1:0] fifo_q_reg;
  logic [PTR_W-1:0]           wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]           count_reg, count_next;
  logic                       err_spurious_reg;

  logic fifo_full, fifo_empty, fifo_head;
  logic sel_valid, sel_src;
  logic push, pop;

  assign fifo_full  = (count_reg == CNT_FULL);
  assign fifo_empty = (count_reg == '0);
  assign fifo_head  = fifo_q_reg[rd_ptr_reg];

  // Winner selection depends only on requests and registered state, never on mem_gnt_i.
  always_comb begin
    sel_valid = 1'b0;
    sel_src   = SRC_INSTR;
    if (state_reg == LOCKED) begin
      sel_valid = 1'b1;
      sel_src   = locked_src_reg;
    end else if (!fifo_full && (instr_req_i || data_req_i)) begin
      sel_valid = 1'b1;
      if (instr_req_i && data_req_i)
        sel_src = (DATA_PRIO != 0) ? SRC_DATA : ~rr_last_reg;
      else
        sel_src = data_req_i ? SRC_DATA : SRC_INSTR;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      locked_src_reg <= SRC_INSTR;
    end else begin
      state_reg      <= state_next;
      locked_src_reg <= locked_src_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    locked_src_next = locked_src_reg;
    case (state_reg)
      IDLE: begin
        if (mem_req_o && !mem_gnt_i) begin
          state_next      = LOCKED;
          locked_src_next = sel_src;
        end
      end
      LOCKED: begin
        if (mem_gnt_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset gates the request so nothing leaks out while rst_ni is low.
  always_comb begin
    mem_req_o   = sel_valid & rst_ni;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      if (sel_src == SRC_DATA) begin
        mem_addr_o  = data_addr_i;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_addr_o  = instr_addr_i;
        mem_be_o    = 4'hF;
      end
    end
    instr_gnt_o = mem_req_o & mem_gnt_i & (sel_src == SRC_INSTR);
    data_gnt_o  = mem_req_o & mem_gnt_i & (sel_src == SRC_DATA);
  end

  assign push = mem_req_o & mem_gnt_i;
  assign pop  = mem_rvalid_i & ~fifo_empty;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_q_reg       <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      rr_last_reg      <= SRC_INSTR;
      err_spurious_reg <= 1'b0;
    end else begin
      if (push) begin
        fifo_q_reg[wr_ptr_reg] <= sel_src;
        wr_ptr_reg             <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
        rr_last_reg            <= sel_src;
      end
      if (pop)
        rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
      count_reg        <= count_next;
      err_spurious_reg <= mem_rvalid_i & fifo_empty;
    end
  end

  assign instr_rvalid_o = pop & (fifo_head == SRC_INSTR);
  assign data_rvalid_o  = pop & (fifo_head == SRC_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign err_spurious_o = err_spurious_reg;

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Directed bench for soc_mem_arbiter (MAX_OUTSTANDING=2, round-robin).
module tb_soc_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] instr_addr_i;
  logic        instr_req_i;
  logic        instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic [31:0] data_addr_i;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic [31:0] mem_addr_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        err_spurious_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  soc_mem_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIO(0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_addr_i(instr_addr_i), .instr_req_i(instr_req_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_addr_i(data_addr_i), .data_req_i(data_req_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .err_spurious_o(err_spurious_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; returns 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_in(input logic ireq, input logic dreq, input logic gnt,
                        input logic rv, input logic [31:0] rd);
    instr_req_i  = ireq;
    data_req_i   = dreq;
    mem_gnt_i    = gnt;
    mem_rvalid_i = rv;
    mem_rdata_i  = rd;
    #1;
  endtask

  task automatic grant_line(input string tag, input logic ig, input logic dg);
    check({tag, " instr_gnt"}, {31'b0, instr_gnt_o}, {31'b0, ig});
    check({tag, " data_gnt"},  {31'b0, data_gnt_o},  {31'b0, dg});
    $display("%0t %s: req=%0b addr=0x%08h igKnt=%0b dgnt=%0b irv=%0b drv=%0b",
             $time, tag, mem_req_o, mem_addr_o, instr_gnt_o, data_gnt_o,
             instr_rvalid_o, data_rvalid_o);
  endtask

  initial begin
    instr_addr_i = 32'h0000_0100;
    data_addr_i  = 32'h0000_0200;
    data_we_i    = 1'b1;
    data_be_i    = 4'h3;
    data_wdata_i = 32'hCAFE_F00D;
    rst_ni       = 1'b0;
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // Reset holds everything quiet even with requests present.
    check("rst mem_req", {31'b0, mem_req_o}, 32'h0);
    grant_line("rst", 1'b0, 1'b0);
    check("rst err", {31'b0, err_spurious_o}, 32'h0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    #2 rst_ni = 1'b1;
    tick();

    // Round-robin alternation, responses routed in order alongside new grants.
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    grant_line("rr c0", 1'b0, 1'b1);
    check("rr c0 addr", mem_addr_o, 32'h200);
    check("rr c0 we", {31'b0, mem_we_o}, 32'h1);
    check("rr c0 be", {28'b0, mem_be_o}, 32'h3);
    check("rr c0 wdata", mem_wdata_o, 32'hCAFE_F00D);
    tick();
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'hA1);
    grant_line("rr c1", 1'b1, 1'b0);
    check("rr c1 addr", mem_addr_o, 32'h100);
    check("rr c1 we", {31'b0, mem_we_o}, 32'h0);
    check("rr c1 be", {28'b0, mem_be_o}, 32'hF);
    check("rr c1 wdata", mem_wdata_o, 32'h0);
    check("rr c1 drv", {31'b0, data_rvalid_o}, 32'h1);
    check("rr c1 drdata", data_rdata_o, 32'hA1);
    tick();
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'hA2);
    grant_line("rr c2", 1'b0, 1'b1);
    check("rr c2 irv", {31'b0, instr_rvalid_o}, 32'h1);
    check("rr c2 drv", {31'b0, data_rvalid_o}, 32'h0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'hA3);
    check("rr c3 drv", {31'b0, data_rvalid_o}, 32'h1);
    check("rr c3 mem_req", {31'b0, mem_req_o}, 32'h0);
    tick();

    // Lock on instruction while data arrives later; then in-order responses.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    grant_line("lk c0", 1'b0, 1'b0);
    check("lk c0 req", {31'b0, mem_req_o}, 32'h1);
    tick();
    for (int c = 1; c < 3; c++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      grant_line($sformatf("lk c%0d", c), 1'b0, 1'b0);
      check($sformatf("lk c%0d addr", c), mem_addr_o, 32'h100);
      tick();
    end
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    grant_line("lk c3", 1'b1, 1'b0);
    check("lk c3 addr", mem_addr_o, 32'h100);
    tick();
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    grant_line("lk c4", 1'b0, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h11);
    check("ord irv", {31'b0, instr_rvalid_o}, 32'h1);
    check("ord drv0", {31'b0, data_rvalid_o}, 32'h0);
    check("ord irdata", instr_rdata_o, 32'h11);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h22);
    check("ord drv", {31'b0, data_rvalid_o}, 32'h1);
    check("ord irv0", {31'b0, instr_rvalid_o}, 32'h0);
    check("ord drdata", data_rdata_o, 32'h22);
    tick();

    // FIFO full blocks a third grant until a response frees a slot.
    for (int c = 0; c < 2; c++) begin
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      grant_line($sformatf("full c%0d", c), 1'b0, 1'b1);
      tick();
    end
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    check("full mem_req", {31'b0, mem_req_o}, 32'h0);
    check("full addr", mem_addr_o, 32'h0);
    grant_line("full c2", 1'b0, 1'b0);
    check("full drdata", data_rdata_o, 32'hDEAD_BEEF);
    check("full drv", {31'b0, data_rvalid_o}, 32'h1);
    tick();
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("full c3 mem_req", {31'b0, mem_req_o}, 32'h1);
    grant_line("full c3", 1'b0, 1'b1);
    tick();
    for (int c = 0; c < 2; c++) begin
      set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      check($sformatf("drain%0d drv", c), {31'b0, data_rvalid_o}, 32'h1);
      tick();
    end

    // Response with nothing outstanding is dropped and flagged one cycle later.
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h55);
    check("spur irv", {31'b0, instr_rvalid_o}, 32'h0);
    check("spur drv", {31'b0, data_rvalid_o}, 32'h0);
    check("spur err early", {31'b0, err_spurious_o}, 32'h0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("spur err", {31'b0, err_spurious_o}, 32'h1);
    tick();
    check("spur err clr", {31'b0, err_spurious_o}, 32'h0);

    // Reset while locked with one outstanding transfer.
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    grant_line("ar pre", 1'b0, 1'b1);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    rst_ni = 1'b0;
    #1;
    check("ar mem_req", {31'b0, mem_req_o}, 32'h0);
    grant_line("ar", 1'b0, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    #2 rst_ni = 1'b1;
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h77);
    check("ar late drv", {31'b0, data_rvalid_o}, 32'h0);
    tick();
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("ar late err", {31'b0, err_spurious_o}, 32'h1);
    grant_line("ar restart", 1'b0, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
